// File: rtl/pipe_stall_ctrl.sv
//============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Stall / flush / bubble controller for a 5-stage in-order
//            pipeline. Arbitrates data-miss, instruction-miss, halt drain,
//            load-use stall and taken-branch events. Drives per-stage write
//            enables and NOP-insertion strobes, and reports halt status.
//
// Ports    : clk               pipeline clock (rising edge)
//            rst               synchronous active-high reset
//            i_stall_req       load-use stall request (combinational)
//            i_branch_taken    branch in ID resolved taken
//            i_hlt_dec         HLT decoded in ID
//            i_i_miss          instruction-memory miss pending (level)
//            i_d_miss          data-memory miss pending (level)
//            i_fill_done       one-cycle pulse: miss fill complete
//            o_pc_we .. o_mem_wb_we   stage write enables
//            o_if_id_flush, o_id_ex_bubble, o_mem_wb_bubble  NOP inserts
//            o_halted          pipeline drained after HLT
//            o_stall_cycles    stall-cycle performance count
//
// Config   : PIPE_STALL_PERF_CNT_EN  defined   -> saturating 16-bit counter
//                                    undefined -> o_stall_cycles = 0
//
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module pipe_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall_req,
    input  logic        i_branch_taken,
    input  logic        i_hlt_dec,
    input  logic        i_i_miss,
    input  logic        i_d_miss,
    input  logic        i_fill_done,
    output logic        o_pc_we,
    output logic        o_if_id_we,
    output logic        o_id_ex_we,
    output logic        o_ex_mem_we,
    output logic        o_mem_wb_we,
    output logic        o_if_id_flush,
    output logic        o_id_ex_bubble,
    output logic        o_mem_wb_bubble,
    output logic        o_halted,
    output logic [15:0] o_stall_cycles
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DMISS  = 3'd1,
        ST_IMISS  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] c_DRAIN_LOAD = 2'd3;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_drain_cnt;
    logic [1:0] w_drain_cnt_nxt;
    // Set when a data miss interrupted DRAIN, so the fill returns there
    // with the drain counter untouched.
    logic       r_ret_drain;
    logic       w_ret_drain_nxt;

    logic w_pc_we;
    logic w_if_id_we;
    logic w_id_ex_we;
    logic w_ex_mem_we;
    logic w_mem_wb_we;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_mem_wb_bubble;
    logic w_halted;

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 2'd0;
            r_ret_drain <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_ret_drain <= w_ret_drain_nxt;
        end
    end

    //------------------------------------------------------------------------
    // Next-state and output decode
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_ret_drain_nxt = r_ret_drain;
        w_pc_we         = 1'b1;
        w_if_id_we      = 1'b1;
        w_id_ex_we      = 1'b1;
        w_ex_mem_we     = 1'b1;
        w_mem_wb_we     = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_mem_wb_bubble = 1'b0;
        w_halted        = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (i_d_miss) begin
                    // Freeze everything up to EX/MEM; WB gets a bubble so the
                    // stalled MEM result is not retired twice.
                    w_pc_we         = 1'b0;
                    w_if_id_we      = 1'b0;
                    w_id_ex_we      = 1'b0;
                    w_ex_mem_we     = 1'b0;
                    w_mem_wb_bubble = 1'b1;
                    w_ret_drain_nxt = 1'b0;
                    w_state_nxt     = ST_DMISS;
                end else if (i_i_miss) begin
                    w_pc_we       = 1'b0;
                    w_if_id_flush = 1'b1;
                    w_state_nxt   = ST_IMISS;
                end else if (i_hlt_dec) begin
                    w_pc_we         = 1'b0;
                    w_if_id_flush   = 1'b1;
                    w_drain_cnt_nxt = c_DRAIN_LOAD;
                    w_state_nxt     = ST_DRAIN;
                end else if (i_stall_req) begin
                    w_pc_we        = 1'b0;
                    w_if_id_we     = 1'b0;
                    w_id_ex_bubble = 1'b1;
                end else if (i_branch_taken) begin
                    w_if_id_flush = 1'b1;
                end
            end

            ST_DMISS: begin
                w_pc_we         = 1'b0;
                w_if_id_we      = 1'b0;
                w_id_ex_we      = 1'b0;
                w_ex_mem_we     = 1'b0;
                w_mem_wb_bubble = 1'b1;
                if (i_fill_done) begin
                    w_ret_drain_nxt = 1'b0;
                    if (r_ret_drain)
                        w_state_nxt = ST_DRAIN;
                    else if (i_i_miss)
                        w_state_nxt = ST_IMISS;
                    else
                        w_state_nxt = ST_RUN;
                end
            end

            ST_IMISS: begin
                if (i_d_miss) begin
                    w_pc_we         = 1'b0;
                    w_if_id_we      = 1'b0;
                    w_id_ex_we      = 1'b0;
                    w_ex_mem_we     = 1'b0;
                    w_mem_wb_bubble = 1'b1;
                    w_ret_drain_nxt = 1'b0;
                    w_state_nxt     = ST_DMISS;
                end else begin
                    w_pc_we       = 1'b0;
                    w_if_id_flush = 1'b1;
                    if (i_fill_done)
                        w_state_nxt = ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (i_d_miss) begin
                    // Counter held; the drain resumes after the fill.
                    w_pc_we         = 1'b0;
                    w_if_id_we      = 1'b0;
                    w_id_ex_we      = 1'b0;
                    w_ex_mem_we     = 1'b0;
                    w_mem_wb_bubble = 1'b1;
                    w_ret_drain_nxt = 1'b1;
                    w_state_nxt     = ST_DMISS;
                end else begin
                    w_pc_we       = 1'b0;
                    w_if_id_flush = 1'b1;
                    if (r_drain_cnt <= 2'd1) begin
                        w_drain_cnt_nxt = 2'd0;
                        w_state_nxt     = ST_HALTED;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - 2'd1;
                    end
                end
            end

            ST_HALTED: begin
                w_pc_we     = 1'b0;
                w_if_id_we  = 1'b0;
                w_id_ex_we  = 1'b0;
                w_ex_mem_we = 1'b0;
                w_mem_wb_we = 1'b0;
                w_halted    = 1'b1;
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // While reset is asserted the outputs already show the RUN idle
        // values, even if the registered state is still HALTED or mid-miss.
        if (rst) begin
            w_pc_we         = 1'b1;
            w_if_id_we      = 1'b1;
            w_id_ex_we      = 1'b1;
            w_ex_mem_we     = 1'b1;
            w_mem_wb_we     = 1'b1;
            w_if_id_flush   = 1'b0;
            w_id_ex_bubble  = 1'b0;
            w_mem_wb_bubble = 1'b0;
            w_halted        = 1'b0;
        end
    end

    assign o_pc_we         = w_pc_we;
    assign o_if_id_we      = w_if_id_we;
    assign o_id_ex_we      = w_id_ex_we;
    assign o_ex_mem_we     = w_ex_mem_we;
    assign o_mem_wb_we     = w_mem_wb_we;
    assign o_if_id_flush   = w_if_id_flush;
    assign o_id_ex_bubble  = w_id_ex_bubble;
    assign o_mem_wb_bubble = w_mem_wb_bubble;
    assign o_halted        = w_halted;

    //------------------------------------------------------------------------
    // Stall-cycle performance counter
    //------------------------------------------------------------------------
`ifdef PIPE_STALL_PERF_CNT_EN
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 16'h0000;
        end else if (!w_pc_we && (r_state != ST_HALTED) &&
                     (r_stall_cycles != c_CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 16'h0001;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = 16'h0000;
`endif

endmodule

`default_nettype wire
